// File: rtl/seg7_mux_capture.sv
// seg7_mux_capture: recovers an N-digit hex value from a multiplexed 7-segment bus.
// Latency: pin change to capture is 2+SETTLE+1 cycles; frame_valid one cycle after the last capture.
// Backpressure: none; passive monitor, outputs are held levels or single-cycle pulses.

module seg7_mux_capture #(
  parameter int N      = 4,
  parameter int SETTLE = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [6:0]     seg,
  input  logic [N-1:0]   dig_n,
  output logic [4*N-1:0] value,
  output logic           frame_valid,
  output logic           frame_err,
  output logic           multi_err
);

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // synchronizer stages
  logic [6:0]     seg_meta;
  logic [6:0]     s_seg;
  logic [N-1:0]   dig_meta;
  logic [N-1:0]   s_dig;

  // stability tracking
  logic           changing;
  logic [7:0]     cnt;
  logic           settled;

  // digit classification
  logic [N-1:0]   en;
  logic           blank;
  logic           onehot;
  logic           conflict;

  // segment decode
  logic [3:0]     dec_nib;
  logic           dec_err;

  // control
  state_t         state;
  state_t         state_nxt;
  logic           cap_load;
  logic           multi_nxt;

  // frame assembly
  logic [N-1:0]   seen;
  logic [4*N-1:0] shadow;
  logic [N-1:0]   err_bits;
  logic           complete;

  // Two-flop synchronizers on the asynchronous pin inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_meta <= '0;
      s_seg    <= '0;
      dig_meta <= '0;
      s_dig    <= '0;
    end else begin
      seg_meta <= seg;
      s_seg    <= seg_meta;
      dig_meta <= dig_n;
      s_dig    <= dig_meta;
    end
  end

  // The value about to enter the synced copies differs from it, so cnt is
  // zero in exactly the cycle where s_seg/s_dig differ from last cycle.
  assign changing = (seg_meta != s_seg) || (dig_meta != s_dig);
  assign settled  = (cnt == SETTLE_CNT);

  // Stability counter: restarts on any change, saturates at SETTLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (changing) begin
      cnt <= '0;
    end else if (!settled) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Digit enables are active-low on the pins; classify the enabled set.
  assign en       = ~s_dig;
  assign blank    = (en == '0);
  assign onehot   = !blank && ((en & (en - N'(1))) == '0);
  assign conflict = !blank && !onehot;

  // Segment pattern {a..g} back to a hex nibble; unknown patterns flag an error.
  always_comb begin
    dec_nib = 4'h0;
    dec_err = 1'b0;
    case (s_seg)
      7'h7E: dec_nib = 4'h0;
      7'h30: dec_nib = 4'h1;
      7'h6D: dec_nib = 4'h2;
      7'h79: dec_nib = 4'h3;
      7'h33: dec_nib = 4'h4;
      7'h5B: dec_nib = 4'h5;
      7'h5F: dec_nib = 4'h6;
      7'h70: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h7B: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h1F: dec_nib = 4'hB;
      7'h4E: dec_nib = 4'hC;
      7'h3D: dec_nib = 4'hD;
      7'h4F: dec_nib = 4'hE;
      7'h47: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'h0;
        dec_err = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: one decision per settled dwell. The shadow write commits on
  // the edge into CAPTURE, so the CAPTURE cycle is the first one showing it.
  // HOLD leaves as soon as cnt has dropped below SETTLE, which also covers a
  // change that landed while CAPTURE was still active.
  always_comb begin
    state_nxt = state;
    cap_load  = 1'b0;
    multi_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (settled) begin
          if (conflict) begin
            multi_nxt = 1'b1;
            state_nxt = HOLD;
          end else if (onehot) begin
            cap_load  = 1'b1;
            state_nxt = CAPTURE;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      CAPTURE: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!settled) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Conflict pulse, registered off the settle decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multi_err <= 1'b0;
    end else begin
      multi_err <= multi_nxt;
    end
  end

  assign complete = &seen;

  // Shadow capture and frame hand-off. A capture in the completion cycle is
  // OR-ed in after seen clears, so it belongs to the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen        <= '0;
      shadow      <= '0;
      err_bits    <= '0;
      value       <= '0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cap_load && en[i]) begin
          shadow[4*i +: 4] <= dec_nib;
          err_bits[i]      <= dec_err;
        end
      end
      seen        <= (complete ? '0 : seen) | (cap_load ? en : '0);
      frame_valid <= complete;
      if (complete) begin
        value     <= shadow;
        frame_err <= |err_bits;
      end
    end
  end

endmodule

// File: tb/tb_seg7_mux_capture.sv
// tb_seg7_mux_capture: drives multiplexed display patterns into seg7_mux_capture.
// Expected frames are queued as each frame's last digit is driven and popped on frame_valid.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_seg7_mux_capture;

  localparam int N      = 4;
  localparam int SETTLE = 16;
  localparam int LAT    = 2 + SETTLE + 1;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic [15:0] val;
    logic        err;
  } frame_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [6:0]     seg = 7'h00;
  logic [N-1:0]   dig_n = '1;
  logic [4*N-1:0] value;
  logic           frame_valid;
  logic           frame_err;
  logic           multi_err;

  frame_t         exp_q [$];
  frame_t         mon_e;
  int             n_checks = 0;
  int             n_fail   = 0;
  int             cyc      = 0;
  int             fv_cnt   = 0;
  int             merr_cnt = 0;
  int             fv_cyc   = -1000;
  int             dig_cyc  = 0;
  int             m0;
  int             f0;
  logic [15:0]    last_val = '0;
  logic           last_err = 1'b0;

  seg7_mux_capture #(.N(N), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .dig_n       (dig_n),
    .value       (value),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .multi_err   (multi_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] model_dec(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (SEG_TAB[i] == p) return {1'b0, 4'(i)};
    end
    return 5'b10000;
  endfunction

  // Frame monitor: pop the scoreboard on every frame_valid, count multi_err pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        fv_cnt++;
        fv_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected frame_valid", 32'(frame_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame value", 32'(value), 32'(mon_e.val));
          check("frame_err", 32'(frame_err), 32'(mon_e.err));
        end
      end
      if (multi_err) merr_cnt++;
    end
  end

  task automatic drive(input logic [N-1:0] dn, input logic [6:0] s, input int cycles);
    dig_n = dn;
    seg   = s;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] s, input int cycles);
    logic [N-1:0] m;
    m = '1;
    m[d] = 1'b0;
    dig_cyc = cyc;
    drive(m, s, cycles);
    drive('1, 7'h00, 5);
  endtask

  task automatic push_frame(input logic [6:0] p0, input logic [6:0] p1,
                            input logic [6:0] p2, input logic [6:0] p3);
    logic [6:0] p [4];
    logic [4:0] r;
    frame_t     f;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      r = model_dec(p[i]);
      f.val[4*i +: 4] = r[3:0];
      f.err = f.err | r[4];
    end
    exp_q.push_back(f);
    last_val = f.val;
    last_err = f.err;
  endtask

  task automatic sweep(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
    show(0, p0, 40);
    show(1, p1, 40);
    show(2, p2, 40);
    push_frame(p0, p1, p2, p3);
    show(3, p3, 40);
    check("frame latency", 32'(fv_cyc - dig_cyc), 32'(LAT + 1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset value", 32'(value), 32'd0);
    check("reset frame_valid", 32'(frame_valid), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset multi_err", 32'(multi_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // One long dwell yields a single capture and no frame.
    show(0, 7'h30, 100);
    check("seen after long dwell", 32'(dut.seen), 32'h1);
    check("no frame after one digit", 32'(fv_cnt), 32'd0);
    show(1, 7'h6D, 40);
    show(2, 7'h79, 40);
    push_frame(7'h30, 7'h6D, 7'h79, 7'h33);
    show(3, 7'h33, 40);

    // Clean sweep, sweep with an undecodable digit, then clean again.
    sweep(7'h79, 7'h6D, 7'h30, 7'h33);
    sweep(7'h79, 7'h6D, 7'h01, 7'h33);
    sweep(7'h79, 7'h6D, 7'h30, 7'h33);
    repeat (20) @(negedge clk);
    check("value held", 32'(value), 32'(last_val));
    check("frame_err held", 32'(frame_err), 32'(last_err));

    // Short glitch on another digit is ignored.
    show(0, 7'h5B, 40);
    drive(4'b1101, 7'h7F, 10);
    drive('1, 7'h00, 5);
    check("seen after glitch", 32'(dut.seen), 32'h1);
    show(1, 7'h5F, 40);
    show(2, 7'h7E, 40);
    push_frame(7'h5B, 7'h5F, 7'h7E, 7'h4F);
    show(3, 7'h4F, 40);

    // Full decode table, four digits at a time.
    for (int g = 0; g < 4; g++) begin
      sweep(SEG_TAB[4*g], SEG_TAB[4*g+1], SEG_TAB[4*g+2], SEG_TAB[4*g+3]);
    end
    // All segments off is an error pattern.
    sweep(7'h00, 7'h7F, 7'h7F, 7'h7F);

    // Two digits enabled: one multi_err pulse; all blank: nothing.
    m0 = merr_cnt;
    f0 = fv_cnt;
    drive(4'b1100, 7'h7E, 50);
    check("multi_err pulses", 32'(merr_cnt - m0), 32'd1);
    drive(4'b1111, 7'h7E, 50);
    check("multi_err after blank", 32'(merr_cnt - m0), 32'd1);
    check("seen after conflict/blank", 32'(dut.seen), 32'h0);
    check("no frame on conflict/blank", 32'(fv_cnt - f0), 32'd0);

    // Recapture overwrites a digit before completion.
    show(0, 7'h30, 40);
    show(1, 7'h30, 40);
    show(2, 7'h30, 40);
    show(0, 7'h7F, 40);
    push_frame(7'h7F, 7'h30, 7'h30, 7'h30);
    show(3, 7'h30, 40);

    // Reset mid-frame discards the partial capture.
    show(0, 7'h30, 40);
    show(1, 7'h30, 40);
    show(2, 7'h30, 40);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("value in reset", 32'(value), 32'd0);
    check("frame_err in reset", 32'(frame_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    f0 = fv_cnt;
    show(3, 7'h7F, 40);
    check("no frame after reset", 32'(fv_cnt - f0), 32'd0);
    check("seen after reset", 32'(dut.seen), 32'h8);
    show(0, 7'h7F, 40);
    show(1, 7'h7F, 40);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    show(2, 7'h7F, 40);
    show(3, 7'h7F, 40);
    check("seen carries into next frame", 32'(dut.seen), 32'h8);

    repeat (30) @(negedge clk);
    check("frames outstanding", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_mux_capture.md
Name: seg7_mux_capture

Overview:
- Receive-side monitor for the multiplexed 7-segment display bus (segments a..g plus per-digit common lines).
- Samples the pin-level segment and digit-select lines, decodes each settled digit back to a hex nibble, and assembles an N-digit value.
- Presents a complete frame once every digit has been seen.
- Used in loopback self-test and in benches to check display drivers from their outputs.

Parameters:
- N, 4: number of multiplexed digits (1..8).
- SETTLE, 16: cycles a digit/segment combination must be stable before capture (2..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- seg  in  7  segment lines {a,b,c,d,e,f,g}; a = bit 6. Active-high (1 = lit). Asynchronous to clk.
- dig_n  in  N  digit common lines; bit i = digit i. Active-low (0 = digit enabled). Asynchronous to clk.
- value  out  4*N  last complete frame; digit i at bits [4i+3:4i].
- frame_valid  out  1  one-cycle pulse when value/frame_err update.
- frame_err  out  1  at least one digit in the latest frame had an undecodable pattern.
- multi_err  out  1  one-cycle pulse when a stable state with more than one digit enabled is detected.

Behaviour:
- Reset (async assert, sync release): value=0, frame_valid=0, frame_err=0, multi_err=0. Seen mask, shadow nibbles, error bits, stability counter and synchronizers all cleared. Reset mid-frame discards partial captures.
- Input sync: seg and dig_n each pass through 2 flip-flops. All logic below uses the synced copies s_seg and s_dig.
- Stability counter cnt (8 bits):
  - cnt=0 whenever {s_seg,s_dig} differs from its previous-cycle value.
  - Otherwise cnt increments, saturating at SETTLE.
- Classification of ~s_dig:
  - All zero: blank, never captured.
  - One-hot: candidate digit.
  - More than one bit set: conflict.
- FSM:
  - IDLE: cnt<SETTLE. On change, stays IDLE.
  - CAPTURE: single cycle, entered when cnt reaches SETTLE with a one-hot candidate.
    - Writes shadow nibble and error bit for that digit, sets seen[i].
    - Goes to HOLD.
  - HOLD: waits for any input change (cnt=0), then returns to IDLE. This guarantees exactly one capture per dwell regardless of dwell length.
  - Conflict at cnt==SETTLE: pulse multi_err for one cycle, go to HOLD, capture nothing.
  - Blank at cnt==SETTLE: go to HOLD, no capture, no error.
- Decode (s_seg hex → nibble):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 77→A, 1F→b, 4E→C, 3D→d, 4F→E, 47→F.
  - Any other pattern, including all-off: nibble 0, error bit 1.
- Recapture: a digit captured again before frame completion overwrites its shadow nibble and error bit.
- Frame completion:
  - On the cycle after seen becomes all-ones, value is loaded from the shadow nibbles.
  - frame_err is loaded as the OR of the error bits.
  - frame_valid pulses high for 1 cycle.
  - seen is cleared in the same cycle.
  - A capture that lands in the completion cycle counts toward the next frame.
- Latency: an input change at the pins reaches capture 2 (sync) + SETTLE + 1 cycles later. frame_valid follows the last digit's capture by 1 cycle.
- value and frame_err hold their values between frames.

Test Plan:
- Drive dig_n=1110, seg=30 for 100 cycles (N=4, SETTLE=16) → one capture only, seen=0001, no frame_valid.
- Cycle digits 0..3 with 79,6D,30,33 (each 40 cycles, 5 blank cycles between) → one frame_valid pulse, value=0x4123, frame_err=0. Capture occurs exactly 19 cycles after each digit's pins go active.
- Same as above but digit 2 shows 0x01 → value=0x4023, frame_err=1. The next clean frame clears frame_err to 0.
- 10-cycle glitch dig_n=1101, seg=7F inserted between digits → ignored: seen unchanged, value unaffected.
- dig_n=1100 stable for 50 cycles → single multi_err pulse, no capture. dig_n=1111 stable → no capture, no error.
- Capture digits 0–2, assert rst for 3 cycles, then capture digit 3 only → no frame_valid. A subsequent full sweep of 8,8,8,8 → value=0x8888.
